// File: rtl/scmi_doorbell_sched.sv
// Round-robin scheduler for SCMI mailbox doorbells: latches doorbell edges and hands one channel at a time to firmware.
// Optional service watchdog enabled by defining SCHED_TIMEOUT_EN.
module scmi_doorbell_sched #(
    parameter int NumChannels   = 64,
    parameter int TimeoutCycles = 1024,
    localparam int ChanW        = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumChannels-1:0] doorbell_i,
    output logic                   req_valid_o,
    output logic [ChanW-1:0]       req_chan_o,
    input  logic                   req_ready_i,
    input  logic                   done_i,
    output logic                   busy_o,
    output logic [NumChannels-1:0] pending_o,
    output logic [15:0]            coalesce_cnt_o,
    output logic                   timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_SERVICE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NumChannels-1:0] r_db_q;
    logic [NumChannels-1:0] r_pending;
    logic [ChanW-1:0]       r_rr_ptr;
    logic [ChanW-1:0]       r_chan;
    logic [15:0]            r_coal;
    logic                   r_timeout;

    logic [NumChannels-1:0] w_rise;
    logic [NumChannels-1:0] w_clr;
    logic                   w_accept;
    logic                   w_load_chan;
    logic                   w_timeout;
    logic                   w_expire;
    logic                   w_found_hi;
    logic                   w_found_lo;
    logic [ChanW-1:0]       w_pick_hi;
    logic [ChanW-1:0]       w_pick_lo;
    logic [ChanW-1:0]       w_pick;
    logic [6:0]             w_coal_inc;
    logic [16:0]            w_coal_sum;

    assign w_rise   = doorbell_i & ~r_db_q;
    assign w_accept = (r_state == S_OFFER) && req_ready_i;

    // Descending scan so the last hit is the lowest index; "hi" is restricted to >= rr_ptr.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_pick_hi  = '0;
        w_pick_lo  = '0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_found_lo = 1'b1;
                w_pick_lo  = ChanW'(i);
                if (ChanW'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_pick_hi  = ChanW'(i);
                end
            end
        end
        w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
    end

    always_comb begin
        w_clr      = '0;
        w_coal_inc = '0;
        for (int i = 0; i < NumChannels; i++) begin
            w_clr[i] = w_accept && (r_chan == ChanW'(i));
        end
        for (int i = 0; i < NumChannels; i++) begin
            if (w_rise[i] && r_pending[i] && !w_clr[i]) begin
                w_coal_inc = w_coal_inc + 7'd1;
            end
        end
        w_coal_sum = {1'b0, r_coal} + {10'd0, w_coal_inc};
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int TmrW = $clog2(TimeoutCycles) + 1;
    logic [TmrW-1:0] r_tmr;

    assign w_expire = (r_tmr == TmrW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmr <= '0;
        end else if (r_state != S_SERVICE) begin
            r_tmr <= '0;
        end else if (!done_i && !w_expire) begin
            r_tmr <= r_tmr + TmrW'(1);
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TimeoutCycles < 2);
    assign w_expire     = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load_chan  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found_lo) begin
                    w_load_chan  = 1'b1;
                    w_state_next = S_OFFER;
                end
            end
            S_OFFER: begin
                if (req_ready_i) w_state_next = S_SERVICE;
            end
            S_SERVICE: begin
                if (done_i) begin
                    w_state_next = S_IDLE;
                end else if (w_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_db_q    <= '0;
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_chan    <= '0;
            r_coal    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_db_q    <= doorbell_i;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_coal    <= w_coal_sum[16] ? 16'hFFFF : w_coal_sum[15:0];
            r_timeout <= w_timeout;
            if (w_load_chan) r_chan <= w_pick;
            if (w_accept) begin
                r_rr_ptr <= (r_chan == ChanW'(NumChannels - 1)) ? '0 : r_chan + ChanW'(1);
            end
        end
    end

    assign req_valid_o    = (r_state == S_OFFER);
    assign busy_o         = (r_state == S_SERVICE);
    assign req_chan_o     = r_chan;
    assign pending_o      = r_pending;
    assign coalesce_cnt_o = r_coal;
    assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_scmi_doorbell_sched.sv
// Directed bench for scmi_doorbell_sched (64 channels, watchdog limit 8 when SCHED_TIMEOUT_EN is defined).
module tb_scmi_doorbell_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [63:0] doorbell_i = '0;
    logic        req_valid_o;
    logic [5:0]  req_chan_o;
    logic        req_ready_i = 1'b0;
    logic        done_i = 1'b0;
    logic        busy_o;
    logic [63:0] pending_o;
    logic [15:0] coalesce_cnt_o;
    logic        timeout_o;

    int n_total = 0;
    int n_bad   = 0;

    scmi_doorbell_sched #(.NumChannels(64), .TimeoutCycles(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .doorbell_i     (doorbell_i),
        .req_valid_o    (req_valid_o),
        .req_chan_o     (req_chan_o),
        .req_ready_i    (req_ready_i),
        .done_i         (done_i),
        .busy_o         (busy_o),
        .pending_o      (pending_o),
        .coalesce_cnt_o (coalesce_cnt_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer_accept(input string tag, input logic [5:0] exp);
        int w = 0;
        while (!req_valid_o && w < 10) begin
            tick();
            w++;
        end
        chk({tag, " valid"}, req_valid_o, 1);
        chk({tag, " chan"}, req_chan_o, exp);
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        chk({tag, " busy"}, busy_o, 1);
    endtask

    task automatic serve_expect(input string tag, input logic [5:0] exp);
        offer_accept(tag, exp);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk({tag, " idle"}, busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=stuck exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        repeat (3) tick();
        chk("rst valid", req_valid_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst chan", req_chan_o, 0);
        chk("rst pending", pending_o, 0);
        chk("rst coal", coalesce_cnt_o, 0);
        chk("rst tmo", timeout_o, 0);
        rst_i = 1'b0;

        // single channel, latency check
        doorbell_i[5] = 1'b1;
        req_ready_i   = 1'b1;
        tick();
        chk("c5 pend set", pending_o, 64'h20);
        chk("c5 not yet valid", req_valid_o, 0);
        tick();
        chk("c5 valid", req_valid_o, 1);
        chk("c5 chan", req_chan_o, 5);
        tick();
        req_ready_i = 1'b0;
        chk("c5 busy", busy_o, 1);
        chk("c5 valid drop", req_valid_o, 0);
        chk("c5 pend clr", pending_o, 0);
        doorbell_i[5] = 1'b0;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("c5 done", busy_o, 0);

        // round robin wrap from rr_ptr=4
        doorbell_i[3] = 1'b1;
        serve_expect("c3", 3);
        doorbell_i = '0;
        tick();
        doorbell_i[0]  = 1'b1;
        doorbell_i[3]  = 1'b1;
        doorbell_i[63] = 1'b1;
        tick();
        doorbell_i = '0;
        chk("rr pend", pending_o, 64'h8000_0000_0000_0009);
        serve_expect("rr1", 63);
        serve_expect("rr2", 0);
        serve_expect("rr3", 3);

        // coalescing while offer is held
        doorbell_i[2] = 1'b1;
        tick();
        tick();
        chk("co valid", req_valid_o, 1);
        chk("co chan", req_chan_o, 2);
        for (int k = 0; k < 3; k++) begin
            doorbell_i[2] = 1'b0;
            tick();
            doorbell_i[2] = 1'b1;
            tick();
        end
        chk("co cnt", coalesce_cnt_o, 3);
        chk("co chan hold", req_chan_o, 2);
        doorbell_i[1] = 1'b1;
        tick();
        tick();
        chk("co chan c1", req_chan_o, 2);
        chk("co pend", pending_o, 64'h6);
        serve_expect("co2", 2);
        serve_expect("co1", 1);
        doorbell_i = '0;

        // rise in the same cycle as accept
        doorbell_i[7] = 1'b1;
        tick();
        tick();
        chk("s7 chan", req_chan_o, 7);
        doorbell_i[7] = 1'b0;
        tick();
        doorbell_i[7] = 1'b1;
        req_ready_i   = 1'b1;
        tick();
        req_ready_i = 1'b0;
        chk("s7 busy", busy_o, 1);
        chk("s7 pend kept", pending_o, 64'h80);
        chk("s7 coal same", coalesce_cnt_o, 3);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        serve_expect("s7 again", 7);
        doorbell_i = '0;

        // service watchdog
        doorbell_i[9] = 1'b1;
        offer_accept("t9", 9);
        doorbell_i = '0;
`ifdef SCHED_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("tmo early", timeout_o, 0);
        end
        tick();
        chk("tmo pulse", timeout_o, 1);
        chk("tmo idle", busy_o, 0);
        tick();
        chk("tmo once", timeout_o, 0);
        tick();
        chk("tmo no repend", req_valid_o, 0);
        chk("tmo pend", pending_o, 0);
`else
        repeat (20) tick();
        chk("notmo busy", busy_o, 1);
        chk("notmo tmo", timeout_o, 0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("notmo done", busy_o, 0);
`endif

        // async reset during service with doorbell held
        doorbell_i[4] = 1'b1;
        offer_accept("r4", 4);
        #3;
        rst_i = 1'b1;
        #1;
        chk("ar busy", busy_o, 0);
        chk("ar valid", req_valid_o, 0);
        chk("ar chan", req_chan_o, 0);
        chk("ar pend", pending_o, 0);
        chk("ar coal", coalesce_cnt_o, 0);
        chk("ar tmo", timeout_o, 0);
        tick();
        rst_i = 1'b0;
        serve_expect("r4 again", 4);
        doorbell_i = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/scmi_doorbell_sched.md
Name: scmi_doorbell_sched

Overview:
Scheduler for the SCMI mailbox doorbell interrupts toward the platform firmware core. It latches doorbell rising edges from all channels and offers one channel at a time, chosen round-robin, over a valid/ready handshake. It holds the channel in service until firmware signals done, so the core handles exactly one mailbox message at a time. It sits between the mailbox register block's doorbell interrupt outputs and the platform core's interrupt/event interface.

Parameters:
NumChannels, 64, number of mailbox channels; legal range 1..64.
ChanW, max(1,$clog2(NumChannels)), width of the channel index (localparam).
TimeoutCycles, 1024, service watchdog limit in cycles, >=2; used only with SCHED_TIMEOUT_EN.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
doorbell_i  in  NumChannels  level doorbell interrupt per channel, from mailbox registers
req_valid_o  out  1  a channel is offered to firmware
req_chan_o  out  ChanW  offered channel index
req_ready_i  in  1  firmware accepts the offered channel
done_i  in  1  one-cycle pulse: firmware finished the channel in service
busy_o  out  1  a channel is in service
pending_o  out  NumChannels  latched, not-yet-accepted doorbells
coalesce_cnt_o  out  16  saturating count of doorbell edges merged into an already-pending bit
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Interface is fixed: one clock, clk_i; reset is asynchronous and active-high, rst_i.
- Reset values: req_valid_o=0, req_chan_o=0, busy_o=0, pending_o=0, coalesce_cnt_o=0, timeout_o=0. Internal doorbell_q=0, rr_ptr=0, FSM=IDLE.
- Edge detect: rise = doorbell_i & ~doorbell_q, and doorbell_q <= doorbell_i every cycle. Because doorbell_q resets to 0, a doorbell held high across reset is captured as a new edge.
- Pending set: pending[i] <= 1 on rise[i].
  - If rise[i] occurs while pending[i]=1 and pending[i] is not being cleared that cycle, coalesce_cnt_o increments by 1 (saturates at 0xFFFF, no wrap). Several coalesced channels in the same cycle add 1 each, with saturation.
- Pending clear: pending[i] <= 0 on accept (req_valid_o && req_ready_i && req_chan_o==i). If rise[i] occurs in the same cycle, set wins: pending stays 1 and the counter does not increment.
- FSM IDLE: busy_o=0, req_valid_o=0. If pending!=0, pick the first set bit at or after rr_ptr (wrapping modulo NumChannels), register it into req_chan_o, then go to OFFER.
- FSM OFFER: req_valid_o=1. req_chan_o stays stable and there is no re-arbitration until accepted.
  - On accept: clear pending[req_chan_o]; rr_ptr <= (req_chan_o==NumChannels-1) ? 0 : req_chan_o+1; go to SERVICE.
  - req_valid_o never drops without an accept, except on reset.
- FSM SERVICE: busy_o=1, req_valid_o=0, and req_chan_o holds the serviced channel. On done_i, go to IDLE.
- done_i outside SERVICE and req_ready_i outside OFFER are ignored.
- Latency: doorbell_i rises before edge E0, pending is set at E0, FSM enters OFFER at E1, so req_valid_o is high 2 cycles after the sampled rise. After done_i, the next offer can be high 2 cycles later (IDLE takes one cycle). Back-to-back service is therefore 1 idle cycle minimum.
- Reset mid-operation clears everything. Offered or in-service channels are not re-offered unless their doorbell_i level is still high, which is caught as a new edge.
- NumChannels=1: rr_ptr is always 0 and req_chan_o is always 0.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined: a counter clears on SERVICE entry and increments each SERVICE cycle without done_i. When it reaches TimeoutCycles-1 without done_i, the next cycle pulses timeout_o for one cycle and the FSM returns to IDLE. The channel is not re-pended.
  - done_i arriving in the same cycle as expiry wins: no timeout pulse.
- Undefined: no counter is built, timeout_o is tied 0, and SERVICE waits indefinitely for done_i.

Test Plan:
- Reset, raise doorbell_i[5], req_ready_i=1 -> req_valid_o=1 with req_chan_o=5 two cycles after the rise; busy_o=1 next cycle; pending_o[5]=0; done_i -> busy_o=0.
- Raise channels 0, 3, 63 simultaneously with rr_ptr=4 (after servicing ch3) -> offers in order 63, 0, 3, each completed via done_i.
- Hold ch2 pending with req_ready_i=0, toggle doorbell_i[2] three times -> coalesce_cnt_o=3; req_chan_o stays 2; a new ch1 rise does not change the offer.
- Rise ch7 in the same cycle as its accept -> pending_o[7]=1 after accept, coalesce_cnt_o unchanged; ch7 is offered again after done_i.
- With SCHED_TIMEOUT_EN and TimeoutCycles=8: accept, then no done_i -> timeout_o pulses exactly once, 8 cycles after SERVICE entry, and FSM returns to IDLE. Without the macro: busy_o stays 1 indefinitely and timeout_o=0.
- Assert rst_i during SERVICE with doorbell_i[4] held high -> all outputs 0 asynchronously; after release, ch4 is re-pended and offered again.
